// File: rtl/ddr2_app_responder_if.sv
// rtl/ddr2_app_responder_if.sv - MIG-style DDR2 app interface bundle
interface ddr2_app_responder_if;
  logic [26:0]  app_addr;
  logic [2:0]   app_cmd;
  logic         app_en;
  logic         app_rdy;
  logic [127:0] app_wdf_data;
  logic [15:0]  app_wdf_mask;
  logic         app_wdf_wren;
  logic         app_wdf_end;
  logic         app_wdf_rdy;
  logic [127:0] app_rd_data;
  logic         app_rd_data_valid;
  logic         app_rd_data_end;
  logic         init_calib_complete;
  logic         proto_err;

  // Controller side: issues commands and write data.
  modport master (
    output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
    input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end,
           init_calib_complete, proto_err
  );

  // Memory side: the responder.
  modport slave (
    input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
    output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end,
           init_calib_complete, proto_err
  );
endinterface

// File: rtl/ddr2_app_responder.sv
// rtl/ddr2_app_responder.sv - on-chip stand-in for the DDR2 MIG user interface
module ddr2_app_responder #(
  parameter int MEM_WORDS_LOG2   = 10,
  parameter int INIT_CYCLES      = 64,
  parameter int RD_LATENCY       = 8,
  parameter int RDY_STALL_PERIOD = 16
) (
  input logic             sys_clk_i,
  input logic             sys_rst,
  ddr2_app_responder_if.slave app
);
  localparam int AW = MEM_WORDS_LOG2;
  localparam logic [16:0] INIT_LAST  = 17'(INIT_CYCLES - 1);
  localparam logic [15:0] STALL_LAST = 16'(RDY_STALL_PERIOD - 1);
  localparam logic [2:0]  CMD_WR = 3'b000;
  localparam logic [2:0]  CMD_RD = 3'b001;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t       state_q, state_d;
  logic [16:0]  init_cnt_q, init_cnt_d;
  logic [15:0]  stall_cnt_q, stall_cnt_d;
  logic         stall_slot;

  logic [2:0]    cmd_op_mem  [4];
  logic [AW-1:0] cmd_idx_mem [4];
  logic [1:0]    cmd_wp_q, cmd_rp_q;
  logic [2:0]    cmd_cnt_q;

  logic [127:0]  wdf_data_mem [4];
  logic [15:0]   wdf_mask_mem [4];
  logic [1:0]    wdf_wp_q, wdf_rp_q;
  logic [2:0]    wdf_cnt_q;

  logic [127:0]  mem [2**AW];

  logic [RD_LATENCY-1:0] pipe_vld_q;
  logic [127:0]          pipe_data_q [RD_LATENCY];
  logic                  rd_vld_q;
  logic [127:0]          rd_data_q;
  logic                  err_q;

  logic          run, cmd_push, wdf_beat, wdf_push, wdf_bad;
  logic          cmd_avail, do_wr, do_rd, do_bad, cmd_pop;
  logic [2:0]    head_op;
  logic [AW-1:0] head_idx;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^{app.app_addr[26:AW+3], app.app_addr[2:0]};

  // Handshake readiness comes only from registered state.
  assign run             = (state_q == ST_RUN);
  assign app.app_rdy     = run & (cmd_cnt_q != 3'd4) & ~stall_slot;
  assign app.app_wdf_rdy = run & (wdf_cnt_q != 3'd4);
  assign cmd_push        = app.app_en & app.app_rdy;
  assign wdf_beat        = app.app_wdf_wren & app.app_wdf_rdy;
  assign wdf_push        = wdf_beat & app.app_wdf_end;
  assign wdf_bad         = wdf_beat & ~app.app_wdf_end;

  // Execute engine: retire at most the head command each cycle, in order.
  assign head_op   = cmd_op_mem[cmd_rp_q];
  assign head_idx  = cmd_idx_mem[cmd_rp_q];
  assign cmd_avail = (cmd_cnt_q != 3'd0);
  assign do_wr     = cmd_avail & (head_op == CMD_WR) & (wdf_cnt_q != 3'd0);
  assign do_rd     = cmd_avail & (head_op == CMD_RD);
  assign do_bad    = cmd_avail & (head_op != CMD_WR) & (head_op != CMD_RD);
  assign cmd_pop   = do_wr | do_rd | do_bad;

  assign app.init_calib_complete = run;
  assign app.proto_err           = err_q;
  assign app.app_rd_data         = rd_data_q;
  assign app.app_rd_data_valid   = rd_vld_q;
  assign app.app_rd_data_end     = rd_vld_q;

  // Calibration FSM next state and init / refresh-stall counters.
  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    stall_slot  = 1'b0;
    stall_cnt_d = 16'd0;
    if (state_q == ST_INIT) begin
      if (init_cnt_q == INIT_LAST) state_d = ST_RUN;
      else                         init_cnt_d = init_cnt_q + 17'd1;
    end
    if (RDY_STALL_PERIOD != 0) begin
      stall_slot  = (stall_cnt_q == STALL_LAST);
      stall_cnt_d = stall_slot ? 16'd0 : stall_cnt_q + 16'd1;
    end
  end

  // Control state, FIFO pointers and the read pipeline.
  always_ff @(posedge sys_clk_i or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
      stall_cnt_q <= '0;
      cmd_wp_q    <= '0;
      cmd_rp_q    <= '0;
      cmd_cnt_q   <= '0;
      wdf_wp_q    <= '0;
      wdf_rp_q    <= '0;
      wdf_cnt_q   <= '0;
      pipe_vld_q  <= '0;
      for (int i = 0; i < RD_LATENCY; i++) pipe_data_q[i] <= '0;
      rd_vld_q    <= 1'b0;
      rd_data_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      if (cmd_push) cmd_wp_q <= cmd_wp_q + 2'd1;
      if (cmd_pop)  cmd_rp_q <= cmd_rp_q + 2'd1;
      cmd_cnt_q <= cmd_cnt_q + {2'b00, cmd_push} - {2'b00, cmd_pop};
      if (wdf_push) wdf_wp_q <= wdf_wp_q + 2'd1;
      if (do_wr)    wdf_rp_q <= wdf_rp_q + 2'd1;
      wdf_cnt_q <= wdf_cnt_q + {2'b00, wdf_push} - {2'b00, do_wr};
      pipe_vld_q[0]  <= do_rd;
      pipe_data_q[0] <= mem[head_idx];
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_vld_q[i]  <= pipe_vld_q[i-1];
        pipe_data_q[i] <= pipe_data_q[i-1];
      end
      rd_vld_q <= pipe_vld_q[RD_LATENCY-1];
      if (pipe_vld_q[RD_LATENCY-1]) rd_data_q <= pipe_data_q[RD_LATENCY-1];
      if (do_bad || wdf_bad) err_q <= 1'b1;
    end
  end

  // FIFO storage and backing memory; contents survive reset.
  always_ff @(posedge sys_clk_i) begin
    if (cmd_push) begin
      cmd_op_mem[cmd_wp_q]  <= app.app_cmd;
      cmd_idx_mem[cmd_wp_q] <= app.app_addr[AW+2:3];
    end
    if (wdf_push) begin
      wdf_data_mem[wdf_wp_q] <= app.app_wdf_data;
      wdf_mask_mem[wdf_wp_q] <= app.app_wdf_mask;
    end
    if (do_wr) begin
      for (int b = 0; b < 16; b++) begin
        if (!wdf_mask_mem[wdf_rp_q][b]) mem[head_idx][8*b +: 8] <= wdf_data_mem[wdf_rp_q][8*b +: 8];
      end
    end
  end
endmodule

// File: tb/tb_ddr2_app_responder.sv
// tb/tb_ddr2_app_responder.sv - self-checking bench for ddr2_app_responder
module tb_ddr2_app_responder;
  localparam logic [2:0] WR = 3'b000;
  localparam logic [2:0] RD = 3'b001;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ddr2_app_responder_if bus();

  ddr2_app_responder #(
    .MEM_WORDS_LOG2(10), .INIT_CYCLES(64), .RD_LATENCY(8), .RDY_STALL_PERIOD(16)
  ) dut (
    .sys_clk_i(clk),
    .sys_rst  (rst_n),
    .app      (bus.slave)
  );

  typedef struct {
    logic [26:0]  raddr;
    logic [127:0] pre;
    logic [26:0]  waddr;
    logic [127:0] wdata;
    logic [15:0]  mask;
    logic [127:0] exp;
  } vec_t;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_valid = 0;
  int last_vcyc = 0;
  int acc_cyc = 0;
  logic [127:0] exp_q[$];
  logic [127:0] model [1024];
  vec_t vt [5];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int widx(input logic [26:0] a);
    return int'(a[12:3]);
  endfunction

  function automatic logic [127:0] merge(input logic [127:0] old, input logic [127:0] d, input logic [15:0] m);
    logic [127:0] r;
    r = old;
    for (int b = 0; b < 16; b++) if (!m[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Scoreboard: every read beat is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && bus.app_rd_data_valid) begin
      n_valid++;
      last_vcyc = cyc;
      check("rd_end", {127'd0, bus.app_rd_data_end}, 128'd1);
      if (exp_q.size() == 0) check("rd_unexpected", 128'(exp_q.size() + 1), 128'd0);
      else check("rd_data", bus.app_rd_data, exp_q.pop_front());
    end
  end

  task automatic send_wdf(input logic [127:0] d, input logic [15:0] m, input logic e);
    bus.app_wdf_data = d;
    bus.app_wdf_mask = m;
    bus.app_wdf_end  = e;
    bus.app_wdf_wren = 1'b1;
    for (int k = 0; k < 100 && !bus.app_wdf_rdy; k++) @(negedge clk);
    check("wdf_rdy_wait", {127'd0, bus.app_wdf_rdy}, 128'd1);
    @(negedge clk);
    bus.app_wdf_wren = 1'b0;
  endtask

  task automatic send_cmd(input logic [2:0] c, input logic [26:0] a, input bit push, input logic [127:0] ev);
    bus.app_cmd  = c;
    bus.app_addr = a;
    bus.app_en   = 1'b1;
    for (int k = 0; k < 100 && !bus.app_rdy; k++) @(negedge clk);
    check("cmd_rdy_wait", {127'd0, bus.app_rdy}, 128'd1);
    @(negedge clk);
    acc_cyc = cyc;
    bus.app_en = 1'b0;
    if (c == RD && push) exp_q.push_back(ev);
  endtask

  task automatic write_word(input logic [26:0] a, input logic [127:0] d, input logic [15:0] m);
    send_wdf(d, m, 1'b1);
    send_cmd(WR, a, 1'b0, '0);
    model[widx(a)] = merge(model[widx(a)], d, m);
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(negedge clk);
    check("drain", 128'(exp_q.size()), 128'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rdy"},   {127'd0, bus.app_rdy}, 128'd0);
    check({tag, "_wrdy"},  {127'd0, bus.app_wdf_rdy}, 128'd0);
    check({tag, "_calib"}, {127'd0, bus.init_calib_complete}, 128'd0);
    check({tag, "_valid"}, {126'd0, bus.app_rd_data_valid, bus.app_rd_data_end}, 128'd0);
    check({tag, "_err"},   {127'd0, bus.proto_err}, 128'd0);
    check({tag, "_data"},  bus.app_rd_data, 128'd0);
  endtask

  // Write stalled for lack of data holds the queue; 6 reads queue behind it.
  task automatic backpressure_test();
    logic [26:0] ra [6];
    int i;
    bit acc, dacc;
    ra = '{27'h140, 27'h40, 27'h88, 27'h1FF8, 27'h100, 27'h140};
    send_cmd(WR, 27'h140, 1'b0, '0);
    model[widx(27'h140)] = 128'hCAFE_F00D_0000_1111_2222_3333_4444_5555;
    i = 0;
    bus.app_cmd = RD;
    bus.app_addr = ra[0];
    bus.app_en = 1'b1;
    for (int k = 0; k < 20; k++) begin
      acc = bus.app_en && bus.app_rdy;
      if (acc) exp_q.push_back(model[widx(ra[i])]);
      @(negedge clk);
      if (acc) begin i++; if (i < 6) bus.app_addr = ra[i]; else bus.app_en = 1'b0; end
    end
    check("bp_accepts", 128'(i), 128'd3);
    check("bp_rdy_low", {127'd0, bus.app_rdy}, 128'd0);
    bus.app_wdf_data = 128'hCAFE_F00D_0000_1111_2222_3333_4444_5555;
    bus.app_wdf_mask = 16'h0000;
    bus.app_wdf_end  = 1'b1;
    bus.app_wdf_wren = 1'b1;
    for (int k = 0; k < 60 && (i < 6 || bus.app_wdf_wren); k++) begin
      acc  = bus.app_en && bus.app_rdy;
      dacc = bus.app_wdf_wren && bus.app_wdf_rdy;
      if (acc) exp_q.push_back(model[widx(ra[i])]);
      @(negedge clk);
      if (acc) begin i++; if (i < 6) bus.app_addr = ra[i]; else bus.app_en = 1'b0; end
      if (dacc) bus.app_wdf_wren = 1'b0;
    end
    bus.app_en = 1'b0;
    bus.app_wdf_wren = 1'b0;
    check("bp_all_accepted", 128'(i), 128'd6);
    wait_drain();
  endtask

  // Continuous reads: one refresh hole per 16 cycles, nothing lost.
  task automatic stall_test();
    int lows, acc, last_low, gap, nv0;
    lows = 0; acc = 0; last_low = -1; gap = 0; nv0 = n_valid;
    bus.app_cmd = RD;
    bus.app_addr = 27'h40;
    bus.app_en = 1'b1;
    for (int k = 0; k < 64; k++) begin
      if (bus.app_rdy) begin
        exp_q.push_back(model[widx(bus.app_addr)]);
        acc++;
      end else begin
        lows++;
        if (last_low >= 0) gap = k - last_low;
        last_low = k;
      end
      @(negedge clk);
      bus.app_addr = acc[0] ? 27'h88 : 27'h40;
    end
    bus.app_en = 1'b0;
    check("stall_lows", 128'(lows), 128'd4);
    check("stall_gap", 128'(gap), 128'd16);
    wait_drain();
    check("stall_valid_count", 128'(n_valid - nv0), 128'(acc));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int flag, nv;
    vt[0] = '{27'h40,   128'h0, 27'h40, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 16'h0000,
              128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210};
    vt[1] = '{27'h40,   {128{1'b1}}, 27'h2040, 128'h0, 16'hFF00,
              128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0000};
    vt[2] = '{27'h88,   {16{8'hAA}}, 27'h8F, {16{8'h55}}, 16'h00FF, {{8{8'h55}}, {8{8'hAA}}}};
    vt[3] = '{27'h1FF8, 128'h0, 27'h7FFFFF8, {4{32'hDEAD_BEEF}}, 16'h5555, {4{32'hDE00_BE00}}};
    vt[4] = '{27'h100,  128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321, 27'h100, 128'h0, 16'hFFFF,
              128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321};

    bus.app_addr = '0; bus.app_cmd = '0; bus.app_en = 1'b0;
    bus.app_wdf_data = '0; bus.app_wdf_mask = '0; bus.app_wdf_wren = 1'b0; bus.app_wdf_end = 1'b0;

    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;

    flag = 0;
    for (int k = 0; k < 63; k++) begin
      @(negedge clk);
      if (bus.init_calib_complete || bus.app_rdy || bus.app_wdf_rdy) flag++;
    end
    check("calib_window_low", 128'(flag), 128'd0);
    @(negedge clk);
    check("calib_rise", {127'd0, bus.init_calib_complete}, 128'd1);
    check("calib_rdy", {127'd0, bus.app_rdy}, 128'd1);
    check("calib_wdf_rdy", {127'd0, bus.app_wdf_rdy}, 128'd1);

    for (int t = 0; t < 5; t++) begin
      write_word(vt[t].raddr, vt[t].pre, 16'h0000);
      write_word(vt[t].waddr, vt[t].wdata, vt[t].mask);
      send_cmd(RD, vt[t].raddr, 1'b1, vt[t].exp);
      wait_drain();
      check("rd_latency", 128'(last_vcyc - acc_cyc), 128'd9);
    end

    backpressure_test();
    stall_test();

    check("err_clear", {127'd0, bus.proto_err}, 128'd0);
    send_cmd(3'b010, 27'h40, 1'b0, '0);
    repeat (2) @(negedge clk);
    check("err_bad_cmd", {127'd0, bus.proto_err}, 128'd1);
    send_cmd(RD, 27'h40, 1'b1, model[8]);
    wait_drain();

    nv = n_valid;
    for (int r = 0; r < 3; r++) send_cmd(RD, 27'h88, 1'b0, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_idle_outputs("midrst");
    rst_n = 1'b1;
    for (int k = 0; k < 200 && !bus.init_calib_complete; k++) @(negedge clk);
    check("recalib", {127'd0, bus.init_calib_complete}, 128'd1);
    check("no_valid_after_rst", 128'(n_valid), 128'(nv));
    check("err_after_rst", {127'd0, bus.proto_err}, 128'd0);
    send_cmd(RD, 27'h140, 1'b1, model[40]);
    wait_drain();

    send_wdf(128'hBAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0, 16'h0000, 1'b0);
    @(negedge clk);
    check("err_wdf_end", {127'd0, bus.proto_err}, 128'd1);
    write_word(27'h40, 128'h5A5A_0000_1234_5678_0000_FFFF_8765_4321, 16'h0000);
    send_cmd(RD, 27'h40, 1'b1, model[8]);
    wait_drain();
    check("rd_latency_final", 128'(last_vcyc - acc_cyc), 128'd9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
